// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to the data cache, formats load data and owns the
// MEM/WB register feeding wb_stage.

typedef struct packed {
  logic       is_load;
  logic       is_store;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       en_rd;
} decoded_inst_t;

module mem_stage #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_LSB = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  decoded_inst_t         ex_inst,
  input  logic                  ex_is_bubble,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic                  wb_stall,
  output logic                  mem_stall,
  output logic                  dc_req_valid,
  input  logic                  dc_req_ready,
  output logic [XLEN-1:0]       dc_req_addr,
  output logic                  dc_req_we,
  output logic [XLEN-1:0]       dc_req_wdata,
  output logic [XLEN/8-1:0]     dc_req_wstrb,
  input  logic                  dc_resp_valid,
  input  logic [XLEN-1:0]       dc_resp_rdata,
  output decoded_inst_t         wb_inst,
  output logic                  wb_is_bubble,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic [XLEN-1:0]       wb_mem_result
);

  localparam int unsigned StrbW = XLEN / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic                w_memop;
  logic [1:0]          w_size;
  logic                w_unsigned;
  logic [ADDR_LSB-1:0] w_off;
  logic [StrbW-1:0]    w_size_mask;
  logic [StrbW-1:0]    w_wstrb;
  logic [XLEN-1:0]     w_wdata;
  logic [XLEN-1:0]     w_addr_aligned;
  logic [XLEN-1:0]     w_load_word;
  logic [XLEN-1:0]     w_load_fmt;

  logic [XLEN-1:0]     r_req_addr;
  logic                r_req_we;
  logic [XLEN-1:0]     r_req_wdata;
  logic [StrbW-1:0]    r_req_wstrb;
  logic [XLEN-1:0]     r_rdata;

  decoded_inst_t       r_wb_inst;
  logic                r_wb_is_bubble;
  logic [XLEN-1:0]     r_wb_alu_result;
  logic [XLEN-1:0]     r_wb_mem_result;

  assign w_memop        = !ex_is_bubble && (ex_inst.is_load || ex_inst.is_store);
  assign w_size         = ex_inst.funct3[1:0];
  assign w_unsigned     = ex_inst.funct3[2];
  assign w_off          = ex_alu_result[ADDR_LSB-1:0];
  assign w_addr_aligned = {ex_alu_result[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};

  // Store lane placement
  always_comb begin
    w_size_mask = '0;
    case (w_size)
      2'd0:    w_size_mask = StrbW'(8'h01);
      2'd1:    w_size_mask = StrbW'(8'h03);
      2'd2:    w_size_mask = StrbW'(8'h0F);
      default: w_size_mask = StrbW'(8'hFF);
    endcase
    w_wstrb = w_size_mask << w_off;
    w_wdata = ex_store_data << {w_off, 3'b000};
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    w_load_word = dc_resp_rdata >> {w_off, 3'b000};
    w_load_fmt  = w_load_word;
    case (w_size)
      2'd0: w_load_fmt = {{(XLEN-8){~w_unsigned & w_load_word[7]}}, w_load_word[7:0]};
      2'd1: w_load_fmt = {{(XLEN-16){~w_unsigned & w_load_word[15]}}, w_load_word[15:0]};
      2'd2: w_load_fmt = {{(XLEN-32){~w_unsigned & w_load_word[31]}}, w_load_word[31:0]};
      default: w_load_fmt = w_load_word;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_memop)       w_state_next = StReq;
      StReq:   if (dc_req_ready)  w_state_next = StWait;
      StWait:  if (dc_resp_valid) w_state_next = StDone;
      StDone:  if (!wb_stall)     w_state_next = StIdle;
      default:                    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request fields are captured on IDLE->REQ so they stay stable until the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_addr  <= '0;
      r_req_we    <= 1'b0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
    end else if (r_state == StIdle && w_memop) begin
      r_req_addr  <= w_addr_aligned;
      r_req_we    <= ex_inst.is_store;
      r_req_wdata <= ex_inst.is_store ? w_wdata : '0;
      r_req_wstrb <= ex_inst.is_store ? w_wstrb : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (r_state == StWait && dc_resp_valid) begin
      r_rdata <= w_load_fmt;
    end
  end

  assign mem_stall    = wb_stall || (w_memop && r_state != StDone);
  assign dc_req_valid = (r_state == StReq);
  assign dc_req_addr  = r_req_addr;
  assign dc_req_we    = r_req_we;
  assign dc_req_wdata = r_req_wdata;
  assign dc_req_wstrb = r_req_wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_inst       <= '0;
      r_wb_is_bubble  <= 1'b1;
      r_wb_alu_result <= '0;
      r_wb_mem_result <= '0;
    end else if (!wb_stall) begin
      if (mem_stall) begin
        r_wb_inst       <= '0;
        r_wb_is_bubble  <= 1'b1;
        r_wb_alu_result <= '0;
        r_wb_mem_result <= '0;
      end else begin
        r_wb_inst       <= ex_inst;
        r_wb_is_bubble  <= ex_is_bubble;
        r_wb_alu_result <= ex_alu_result;
        r_wb_mem_result <= (!ex_is_bubble && ex_inst.is_load) ? r_rdata : '0;
      end
    end
  end

  assign wb_inst       = r_wb_inst;
  assign wb_is_bubble  = r_wb_is_bubble;
  assign wb_alu_result = r_wb_alu_result;
  assign wb_mem_result = r_wb_mem_result;

endmodule
